// File: rtl/burst_tx_pkg.sv
// burst_tx_pkg: shared state encoding, frame and checksum constants.
// Exports state_t, FRAME_BITS, CHK_INIT and the ptr_w() width helper.
package burst_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    SEND_START,
    SEND_DATA,
    SEND_STOP
  } state_t;

  localparam int FRAME_BITS = 10;
  localparam logic [7:0] CHK_INIT = 8'h00;

  function automatic int ptr_w(input int d);
    return (d > 1) ? $clog2(d) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// uart_tx_byte: one 8N1 frame per start pulse, LSB first, idle high.
// Ports: clk, reset, start, data[7:0] in; tx, frame_done out.
module uart_tx_byte
  import burst_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       frame_done
);

  localparam int CW = ptr_w(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST =
    CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0] BIT_LAST =
    3'(FRAME_BITS - 3);

  state_t ph_q, ph_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] sh_q, sh_d;
  logic tx_q, tx_d;
  logic cnt_end;

  assign cnt_end = (cnt_q == CNT_LAST);
  // Last cycle of the stop bit; a start here
  // chains the next frame with no idle gap.
  assign frame_done = (ph_q == SEND_STOP) && cnt_end;
  assign tx = tx_q;

  always_comb begin
    ph_d  = ph_q;
    bit_d = bit_q;
    sh_d  = sh_q;
    tx_d  = tx_q;
    cnt_d = cnt_end ? '0 : cnt_q + 1'b1;
    if (start) begin
      ph_d  = SEND_START;
      cnt_d = '0;
      bit_d = '0;
      sh_d  = data;
      tx_d  = 1'b0;
    end else begin
      unique case (ph_q)
        SEND_START: begin
          if (cnt_end) begin
            ph_d = SEND_DATA;
            tx_d = sh_q[0];
          end
        end
        SEND_DATA: begin
          if (cnt_end) begin
            if (bit_q == BIT_LAST) begin
              ph_d = SEND_STOP;
              tx_d = 1'b1;
            end else begin
              bit_d = bit_q + 1'b1;
              sh_d  = sh_q >> 1;
              tx_d  = sh_q[1];
            end
          end
        end
        SEND_STOP: begin
          if (cnt_end) begin
            ph_d = IDLE;
            tx_d = 1'b1;
          end
        end
        default: begin
          ph_d  = IDLE;
          cnt_d = '0;
          tx_d  = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ph_q  <= IDLE;
      cnt_q <= '0;
      bit_q <= '0;
      sh_q  <= '0;
      tx_q  <= 1'b1;
    end else begin
      ph_q  <= ph_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      sh_q  <= sh_d;
      tx_q  <= tx_d;
    end
  end

endmodule

// File: rtl/burst_serial_tx.sv
// burst_serial_tx: buffers a byte burst plus XOR checksum, sends 8N1.
// Ports: clk, reset, i_valid, Din[7:0] in; busy, tx, done out.
module burst_serial_tx
  import burst_tx_pkg::*;
#(
  parameter int DEPTH        = 16,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_valid,
  input  logic [7:0] Din,
  output logic       busy,
  output logic       tx,
  output logic       done
);

  localparam int PW = ptr_w(DEPTH);
  localparam logic [PW-1:0] WR_LAST =
    PW'(DEPTH - 1);

  // SEND_START here covers the whole frame
  // train; bit phases live in uart_tx_byte.
  state_t state_q, state_d;
  logic [7:0] mem_q [DEPTH];
  logic [7:0] mem_d [DEPTH];
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [PW:0] count_q, count_d;
  logic [PW:0] rd_nxt;
  logic [7:0] chk_q, chk_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic start;
  logic [7:0] tx_data;
  logic frame_done;

  assign busy = busy_q;
  assign done = done_q;

  always_comb begin
    state_d = state_q;
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    chk_d   = chk_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    start   = 1'b0;
    rd_nxt  = {1'b0, rd_q} + 1'b1;
    tx_data = mem_q[rd_q];
    unique case (state_q)
      IDLE: begin
        if (i_valid) begin
          mem_d[wr_q] = Din;
          wr_d    = wr_q + 1'b1;
          chk_d   = CHK_INIT ^ Din;
          busy_d  = 1'b1;
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        if (i_valid) begin
          if (wr_q != WR_LAST) begin
            mem_d[wr_q] = Din;
            wr_d  = wr_q + 1'b1;
            chk_d = chk_q ^ Din;
          end
        end else begin
          mem_d[wr_q] = chk_q;
          count_d = {1'b0, wr_q} + 1'b1;
          start   = 1'b1;
          state_d = SEND_START;
        end
      end
      SEND_START: begin
        if (frame_done) begin
          if (rd_nxt < count_q) begin
            rd_d    = rd_nxt[PW-1:0];
            tx_data = mem_q[rd_nxt[PW-1:0]];
            start   = 1'b1;
          end else begin
            state_d = IDLE;
            wr_d    = '0;
            rd_d    = '0;
            count_d = '0;
            chk_d   = CHK_INIT;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      chk_q   <= CHK_INIT;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
      chk_q   <= chk_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .data      (tx_data),
    .tx        (tx),
    .frame_done(frame_done)
  );

endmodule

// File: tb/tb_burst_serial_tx.sv
// tb_burst_serial_tx: directed bursts against a frame-level model.
// Checks tx/busy/done every cycle plus literal frame lists.
module tb_burst_serial_tx;

  localparam int CPB = 4;
  localparam int BT  = 10 * CPB;

  typedef logic [7:0] bq_t[$];

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic i_valid = 1'b0;
  logic [7:0] Din = 8'h00;
  logic busy, tx, done;

  burst_serial_tx #(
    .DEPTH(16),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .i_valid(i_valid),
    .Din    (Din),
    .busy   (busy),
    .tx     (tx),
    .done   (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  // model: one burst described by its edge numbers
  bit   m_on = 1'b0;
  bit   started = 1'b0;
  int   m_c0 = 0;
  int   m_e = 0;
  int   m_end = -10;
  int   m_prev_end = -10;
  bq_t  exp_q;
  bq_t  rx_q;
  logic [7:0] rx_byte;
  int   done_k = -1;
  logic busy_at_done = 1'bx;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      if (n_fail <= 30)
        $display("FAIL %s @cyc %0d: got %0h want %0h",
                 nm, cyc, act, want);
    end
  endtask

  function automatic logic exp_tx(input int k);
    int t, f, b;
    if (!m_on || k < m_e || k >= m_end) return 1'b1;
    t = k - m_e;
    f = t / BT;
    b = (t % BT) / CPB;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return exp_q[f][b-1];
  endfunction

  function automatic logic exp_busy(input int k);
    return m_on && k >= m_c0 && k < m_end;
  endfunction

  function automatic logic exp_done(input int k);
    return (k == m_end) || (k == m_prev_end);
  endfunction

  int k_s, t_s, ph_s, b_s;
  always @(negedge clk) begin
    k_s = cyc;
    if (started && !reset) begin
      chk("tx", 32'(tx), 32'(exp_tx(k_s)));
      chk("busy", 32'(busy), 32'(exp_busy(k_s)));
      chk("done", 32'(done), 32'(exp_done(k_s)));
      if (done === 1'b1) begin
        done_k = k_s;
        busy_at_done = busy;
      end
      if (m_on && k_s >= m_e && k_s < m_end) begin
        t_s  = k_s - m_e;
        ph_s = t_s % BT;
        b_s  = ph_s / CPB;
        if (ph_s % CPB == CPB / 2) begin
          if (b_s >= 1 && b_s <= 8)
            rx_byte[b_s-1] = tx;
          if (b_s == 9)
            rx_q.push_back(rx_byte);
        end
      end
    end
  end

  // Call at #1 after a posedge; returns with i_valid low.
  task automatic burst(input bq_t b);
    int n;
    int np;
    logic [7:0] x;
    n  = b.size();
    np = (n > 15) ? 15 : n;
    x  = 8'h00;
    m_prev_end = m_end;
    m_c0 = cyc + 1;
    m_e  = m_c0 + n;
    exp_q = {};
    for (int i = 0; i < np; i++) begin
      exp_q.push_back(b[i]);
      x ^= b[i];
    end
    exp_q.push_back(x);
    m_end = m_e + exp_q.size() * BT;
    rx_q = {};
    done_k = -1;
    m_on = 1'b1;
    for (int i = 0; i < n; i++) begin
      i_valid = 1'b1;
      Din = b[i];
      @(posedge clk); #1;
    end
    i_valid = 1'b0;
    Din = 8'h00;
  endtask

  task automatic finish_burst(input bit ff);
    while (cyc < m_end + 2) begin
      i_valid = ff && (cyc % 17 == 0) &&
                (cyc < m_end - 5);
      Din = i_valid ? 8'hFF : 8'h00;
      @(posedge clk); #1;
    end
    i_valid = 1'b0;
    Din = 8'h00;
  endtask

  task automatic check_frames(input string nm,
                              input bq_t lit);
    chk({nm, "_nframes"}, 32'(rx_q.size()),
        32'(lit.size()));
    for (int i = 0; i < lit.size(); i++)
      chk($sformatf("%s_frame%0d", nm, i),
          (i < rx_q.size()) ? 32'(rx_q[i]) : 'x,
          32'(lit[i]));
  endtask

  task automatic wait_idle(input string nm);
    int g;
    g = 0;
    while (busy !== 1'b0 && g < 3000) begin
      @(posedge clk); #1;
      g++;
    end
    chk({nm, "_busy_timeout"}, 32'(g < 3000), 32'd1);
  endtask

  task automatic lifo_burst(input bq_t w);
    bq_t r;
    wait_idle("lifo");
    r = {};
    for (int i = w.size() - 1; i >= 0; i--)
      r.push_back(w[i]);
    burst(r);
  endtask

  bq_t q;
  int first_end;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    started = 1'b1;
    @(negedge clk);
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    @(posedge clk); #1;

    q = '{8'hA5, 8'h3C, 8'h0F};
    burst(q);
    finish_burst(1'b0);
    check_frames("A", '{8'hA5, 8'h3C, 8'h0F, 8'h96});
    chk("A_done_lat", 32'(done_k - m_e), 32'd160);

    q = '{8'h55};
    burst(q);
    finish_burst(1'b0);
    check_frames("B", '{8'h55, 8'h55});
    chk("B_done_lat", 32'(done_k - m_e), 32'd80);
    chk("B_busy_at_done", 32'(busy_at_done), 32'd0);

    q = {};
    for (int i = 1; i <= 17; i++) q.push_back(8'(i));
    burst(q);
    finish_burst(1'b0);
    check_frames("C", '{8'h01, 8'h02, 8'h03, 8'h04,
                        8'h05, 8'h06, 8'h07, 8'h08,
                        8'h09, 8'h0A, 8'h0B, 8'h0C,
                        8'h0D, 8'h0E, 8'h0F, 8'h00});
    chk("C_done_lat", 32'(done_k - m_e), 32'd640);

    q = '{8'h12, 8'h34, 8'h56};
    burst(q);
    while (cyc < m_e + 10) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    m_on = 1'b0;
    m_end = -10;
    m_prev_end = -10;
    rx_q = {};
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("D_rst_tx", 32'(tx), 32'd1);
    chk("D_rst_busy", 32'(busy), 32'd0);
    chk("D_rst_done", 32'(done), 32'd0);
    @(posedge clk); #1;
    q = '{8'h22};
    burst(q);
    finish_burst(1'b0);
    check_frames("D", '{8'h22, 8'h22});

    q = '{8'hA5, 8'h3C, 8'h0F};
    burst(q);
    finish_burst(1'b1);
    check_frames("E", '{8'hA5, 8'h3C, 8'h0F, 8'h96});

    q = '{8'h11, 8'h22, 8'h33};
    lifo_burst(q);
    first_end = m_end;
    wait_idle("F1");
    check_frames("F1", '{8'h33, 8'h22, 8'h11, 8'h00});
    q = '{8'h44};
    lifo_burst(q);
    chk("F_held_off", 32'(m_c0 > first_end), 32'd1);
    finish_burst(1'b0);
    check_frames("F2", '{8'h44, 8'h44});

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation timed out");
    $fatal(1, "timeout");
  end

endmodule
